// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - 8-bit ALU opcodes, 16-bit word command encoding and status flag indices.
package alu_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_CPC = 4'b0001;
  localparam logic [3:0] ALU_SBC = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_CP  = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_ADC = 4'b0111;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_EOR = 4'b1001;
  localparam logic [3:0] ALU_OR  = 4'b1010;
  localparam logic [3:0] ALU_MOV = 4'b1011;

  typedef enum logic [2:0] {
    CMD_ADDW = 3'b000,
    CMD_SUBW = 3'b001,
    CMD_CPW  = 3'b010,
    CMD_ANDW = 3'b011,
    CMD_ORW  = 3'b100,
    CMD_EORW = 3'b101,
    CMD_MOVW = 3'b110,
    CMD_RSVD = 3'b111
  } word_cmd_e;

  localparam int FLAG_H = 5;
  localparam int FLAG_S = 4;
  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // High pass uses the carry-consuming variant so the low-byte carry/borrow chains in.
  function automatic logic [3:0] word_op(input word_cmd_e cmd, input logic hi);
    logic [3:0] op;
    op = ALU_NOP;
    case (cmd)
      CMD_ADDW: op = hi ? ALU_ADC : ALU_ADD;
      CMD_SUBW: op = hi ? ALU_SBC : ALU_SUB;
      CMD_CPW:  op = hi ? ALU_CPC : ALU_CP;
      CMD_ANDW: op = ALU_AND;
      CMD_ORW:  op = ALU_OR;
      CMD_EORW: op = ALU_EOR;
      CMD_MOVW: op = ALU_MOV;
      default:  op = ALU_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - runs 16-bit word ops on an 8-bit ALU as low then high byte passes.
// Optional ALU_SEQ_IMM_EN: i_imm_sel swaps the source word for zero-extended i_imm.
module alu_seq
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_cmd,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_imm_sel,
  input  logic [5:0]  i_imm,
  input  logic [7:0]  i_sreg,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_wr_en,
  output logic [15:0] o_result,
  output logic [7:0]  o_sreg,
  output logic [3:0]  o_alu_operation,
  output logic [7:0]  o_alu_op1,
  output logic [7:0]  o_alu_op2,
  output logic [5:0]  o_alu_flags,
  input  logic [7:0]  i_alu_result,
  input  logic [5:0]  i_alu_flags
);

  localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  word_cmd_e   cmd_q, cmd_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [7:0]  sreg_q, sreg_d;
  logic [7:0]  lo_res_q, lo_res_d;
  logic [5:0]  lo_flags_q, lo_flags_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  sreg_out_q, sreg_out_d;
  logic [15:0] src_word;
  logic        pass_end;

`ifdef ALU_SEQ_IMM_EN
  assign src_word = i_imm_sel ? {10'b0, i_imm} : i_b;
`else
  logic unused_imm;
  assign unused_imm = ^{i_imm_sel, i_imm};
  assign src_word   = i_b;
`endif

  assign pass_end = (cnt_q == CW'(ALU_LAT));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cmd_d           = cmd_q;
    a_d             = a_q;
    b_d             = b_q;
    sreg_d          = sreg_q;
    lo_res_d        = lo_res_q;
    lo_flags_d      = lo_flags_q;
    result_d        = result_q;
    sreg_out_d      = sreg_out_q;
    o_alu_operation = ALU_NOP;
    o_alu_op1       = 8'h00;
    o_alu_op2       = 8'h00;
    o_alu_flags     = 6'h00;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_start) begin
          cmd_d  = word_cmd_e'(i_cmd);
          a_d    = i_a;
          b_d    = src_word;
          sreg_d = i_sreg;
          cnt_d  = '0;
          if (word_cmd_e'(i_cmd) == CMD_RSVD) begin
            state_d    = S_DONE;
            result_d   = i_a;
            sreg_out_d = i_sreg;
          end else begin
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        o_alu_operation = word_op(cmd_q, 1'b0);
        o_alu_op1       = a_q[7:0];
        o_alu_op2       = b_q[7:0];
        // Seed the chain: no carry in, and Z=1 so a chained-Z op reduces to the low byte.
        o_alu_flags     = {sreg_q[5:2], 1'b1, 1'b0};
        if (pass_end) begin
          lo_res_d   = i_alu_result;
          lo_flags_d = i_alu_flags;
          cnt_d      = '0;
          state_d    = S_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HI: begin
        o_alu_operation = word_op(cmd_q, 1'b1);
        o_alu_op1       = a_q[15:8];
        o_alu_op2       = b_q[15:8];
        o_alu_flags     = lo_flags_q;
        if (pass_end) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (cmd_q == CMD_MOVW) begin
            result_d   = b_q;
            sreg_out_d = sreg_q;
          end else begin
            result_d   = {i_alu_result, lo_res_q};
            sreg_out_d = {sreg_q[7:6], i_alu_flags[FLAG_H:FLAG_N],
                          i_alu_flags[FLAG_Z] & lo_flags_q[FLAG_Z], i_alu_flags[FLAG_C]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= CMD_ADDW;
      a_q        <= '0;
      b_q        <= '0;
      sreg_q     <= '0;
      lo_res_q   <= '0;
      lo_flags_q <= '0;
      result_q   <= '0;
      sreg_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sreg_q     <= sreg_d;
      lo_res_q   <= lo_res_d;
      lo_flags_q <= lo_flags_d;
      result_q   <= result_d;
      sreg_out_q <= sreg_out_d;
    end
  end

  assign o_busy   = (state_q == S_LO) || (state_q == S_HI);
  assign o_done   = (state_q == S_DONE);
  assign o_err    = o_done && (cmd_q == CMD_RSVD);
  assign o_wr_en  = o_done && (cmd_q != CMD_RSVD) && (cmd_q != CMD_CPW);
  assign o_result = result_q;
  assign o_sreg   = sreg_out_q;

endmodule
